// File: rtl/volatility_window_reader_if.sv
// volatility_window_reader_if
//   Bundles the request, window-RAM read port, write-side snoop and response
//   signals of the volatility window reader.
//   slave  : the reader engine (takes requests, drives reads and responses)
//   master : the requester / memory / pricing side
//   Widths follow the reader: stock ID = max(1,clog2(NUM_STOCKS)),
//   address = clog2(NUM_STOCKS*BUFFER_SIZE), sum/sum_sq/var as derived below.
interface volatility_window_reader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 20,
    parameter int NUM_STOCKS  = 4
);
    localparam int IDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int AW  = ((NUM_STOCKS * BUFFER_SIZE) > 1) ? $clog2(NUM_STOCKS * BUFFER_SIZE) : 1;
    localparam int LW  = $clog2(BUFFER_SIZE);
    localparam int SW  = DATA_WIDTH + LW;
    localparam int QW  = 2 * DATA_WIDTH + LW;
    localparam int VW  = 2 * DATA_WIDTH + 2 * LW;

    logic                  i_req_valid;
    logic [IDW-1:0]        i_req_stock_id;
    logic                  o_req_ready;
    logic                  o_rd_en;
    logic [AW-1:0]         o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  i_wr_valid;
    logic [IDW-1:0]        i_wr_stock_id;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic [IDW-1:0]        o_resp_stock_id;
    logic [SW-1:0]         o_sum;
    logic [QW-1:0]         o_sum_sq;
    logic [VW-1:0]         o_var_scaled;
    logic                  o_resp_err;
    logic                  o_resp_stale;

    modport slave (
        input  i_req_valid, i_req_stock_id, i_rd_data, i_wr_valid, i_wr_stock_id, i_resp_ready,
        output o_req_ready, o_rd_en, o_rd_addr, o_resp_valid, o_resp_stock_id,
               o_sum, o_sum_sq, o_var_scaled, o_resp_err, o_resp_stale
    );

    modport master (
        output i_req_valid, i_req_stock_id, i_rd_data, i_wr_valid, i_wr_stock_id, i_resp_ready,
        input  o_req_ready, o_rd_en, o_rd_addr, o_resp_valid, o_resp_stock_id,
               o_sum, o_sum_sq, o_var_scaled, o_resp_err, o_resp_stale
    );
endinterface

// File: rtl/volatility_window_reader.sv
// volatility_window_reader
//   Scans one stock's BUFFER_SIZE-entry mid-price window through a 1-cycle
//   latency read port, accumulating sum and sum of squares, and returns both
//   plus BUFFER_SIZE*sum_sq - sum^2 (scaled variance numerator).
//   Ports:
//     i_clk      clock
//     i_reset_n  synchronous active-low reset
//     bus        volatility_window_reader_if.slave (request, read port,
//                write snoop, response with valid/ready hold)
//   Optional feature: define VOLATILITY_READER_STALE_EN to flag responses
//   whose window was written (snoop) while the scan was in flight; otherwise
//   o_resp_stale stays 0 and the snoop inputs are ignored.
module volatility_window_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 20,
    parameter int NUM_STOCKS  = 4
) (
    input logic                         i_clk,
    input logic                         i_reset_n,
    volatility_window_reader_if.slave   bus
);
    localparam int IDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int AW  = ((NUM_STOCKS * BUFFER_SIZE) > 1) ? $clog2(NUM_STOCKS * BUFFER_SIZE) : 1;
    localparam int KW  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int LW  = $clog2(BUFFER_SIZE);
    localparam int DW  = DATA_WIDTH;
    localparam int SW  = DW + LW;
    localparam int QW  = 2 * DW + LW;
    localparam int VW  = 2 * DW + 2 * LW;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, FINAL, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] id_q;
    logic [KW-1:0]  k;
    logic           rd_pend;   // read data is on i_rd_data this cycle
    logic [SW-1:0]  acc_sum;
    logic [QW-1:0]  acc_sq;
    logic           stale_q;

    logic [2*DW-1:0] sq;
    logic            req_oor;
    logic [AW-1:0]   req_base;
    logic [VW-1:0]   var_calc;
    logic            wr_hit;

    assign sq       = {{DW{1'b0}}, bus.i_rd_data} * {{DW{1'b0}}, bus.i_rd_data};
    assign req_oor  = 32'(bus.i_req_stock_id) >= NUM_STOCKS;
    assign req_base = AW'(32'(bus.i_req_stock_id) * BUFFER_SIZE);
    // Both terms fit in VW bits and the difference is non-negative, so the
    // truncated VW-bit arithmetic is exact.
    assign var_calc = VW'(BUFFER_SIZE) * VW'(acc_sq) - VW'(acc_sum) * VW'(acc_sum);

`ifdef VOLATILITY_READER_STALE_EN
    assign wr_hit = bus.i_wr_valid && (bus.i_wr_stock_id == id_q);
`else
    assign wr_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state                <= IDLE;
            id_q                 <= '0;
            k                    <= '0;
            rd_pend              <= 1'b0;
            acc_sum              <= '0;
            acc_sq               <= '0;
            stale_q              <= 1'b0;
            bus.o_req_ready      <= 1'b1;
            bus.o_rd_en          <= 1'b0;
            bus.o_rd_addr        <= '0;
            bus.o_resp_valid     <= 1'b0;
            bus.o_resp_stock_id  <= '0;
            bus.o_sum            <= '0;
            bus.o_sum_sq         <= '0;
            bus.o_var_scaled     <= '0;
            bus.o_resp_err       <= 1'b0;
            bus.o_resp_stale     <= 1'b0;
        end else begin
            // Accumulate the beat returned for the previous cycle's strobe;
            // this covers READ cycles 2.. and the DRAIN cycle.
            rd_pend <= bus.o_rd_en;
            if (rd_pend) begin
                acc_sum <= acc_sum + SW'(bus.i_rd_data);
                acc_sq  <= acc_sq + QW'(sq);
            end

            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        id_q                <= bus.i_req_stock_id;
                        k                   <= '0;
                        acc_sum             <= '0;
                        acc_sq              <= '0;
                        stale_q             <= 1'b0;
                        bus.o_req_ready     <= 1'b0;
                        bus.o_resp_stock_id <= bus.i_req_stock_id;
                        bus.o_sum           <= '0;
                        bus.o_sum_sq        <= '0;
                        bus.o_var_scaled    <= '0;
                        bus.o_resp_err      <= req_oor;
                        bus.o_resp_stale    <= 1'b0;
                        if (req_oor) begin
                            bus.o_resp_valid <= 1'b1;
                            state            <= RESP;
                        end else begin
                            bus.o_rd_en   <= 1'b1;
                            bus.o_rd_addr <= req_base;
                            state         <= READ;
                        end
                    end
                end
                READ: begin
                    if (wr_hit) stale_q <= 1'b1;
                    if (k == KW'(BUFFER_SIZE - 1)) begin
                        bus.o_rd_en <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        k             <= k + KW'(1);
                        bus.o_rd_addr <= bus.o_rd_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (wr_hit) stale_q <= 1'b1;
                    state <= FINAL;
                end
                FINAL: begin
                    bus.o_sum        <= acc_sum;
                    bus.o_sum_sq     <= acc_sq;
                    bus.o_var_scaled <= var_calc;
                    bus.o_resp_stale <= stale_q;
                    bus.o_resp_valid <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (bus.i_resp_ready) begin
                        bus.o_resp_valid <= 1'b0;
                        bus.o_req_ready  <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_volatility_window_reader.sv
module tb_volatility_window_reader;
    localparam int DW = 32;
    localparam int BS = 4;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    volatility_window_reader_if #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(NS)) bus ();

    volatility_window_reader #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(NS)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Window RAM: data one cycle after the strobe.
    logic [31:0] mem [NS*BS];
    always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // phase = cycles since the accepting edge (0 = idle)
    int           phase = 0;
    int           m_id = 0;
    logic         m_err = 1'b0;
    logic         m_stale = 1'b0;
    logic [127:0] m_sum, m_sq, m_var, d;
    logic         exp_v, exp_rd;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            exp_rd = !m_err && phase >= 1 && phase <= BS;
            exp_v  = phase != 0 && (m_err || phase >= BS + 3);
            chk("req_ready", bus.o_req_ready, phase == 0);
            chk("rd_en", bus.o_rd_en, exp_rd);
            if (exp_rd) chk("rd_addr", bus.o_rd_addr, m_id * BS + phase - 1);
            chk("resp_valid", bus.o_resp_valid, exp_v);
            if (exp_v) begin
                chk("resp_id", bus.o_resp_stock_id, m_id);
                chk("sum", bus.o_sum, m_sum);
                chk("sum_sq", bus.o_sum_sq, m_sq);
                chk("var", bus.o_var_scaled, m_var);
                chk("err", bus.o_resp_err, m_err);
                chk("stale", bus.o_resp_stale, m_stale);
            end
`ifdef VOLATILITY_READER_STALE_EN
            if (phase >= 1 && phase <= BS + 1 && bus.i_wr_valid && bus.i_wr_stock_id == m_id)
                m_stale = 1'b1;
`endif
            if (!rst_n) phase = 0;
            else if (phase == 0) begin
                if (bus.i_req_valid) begin
                    m_id = int'(bus.i_req_stock_id);
                    m_err = m_id >= NS;
                    m_stale = 1'b0;
                    m_sum = 0;
                    m_sq = 0;
                    if (!m_err)
                        for (int i = 0; i < BS; i++) begin
                            d = mem[m_id * BS + i];
                            m_sum += d;
                            m_sq += d * d;
                        end
                    m_var = BS * m_sq - m_sum * m_sum;
                    phase = 1;
                end
            end else if (exp_v && bus.i_resp_ready) phase = 0;
            else phase++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input int id);
        bus.i_req_valid = 1'b1;
        bus.i_req_stock_id = 2'(id);
        tick;
        bus.i_req_valid = 1'b0;
    endtask

    // Returns the cycle number (relative to the accepting edge) at which
    // o_resp_valid is seen; start = current cycle number.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!bus.o_resp_valid && lat < 40) begin
            tick;
            lat++;
        end
        if (!bus.o_resp_valid) chk("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_resp;
        bus.i_resp_ready = 1'b1;
        tick;
        bus.i_resp_ready = 1'b0;
    endtask

    task automatic stale_scan(input int wr_id, input int wr_cycle, input logic exp);
        int c, lat;
        req(2);
        c = 1;
        while (c < wr_cycle) begin
            tick;
            c++;
        end
        bus.i_wr_valid = 1'b1;
        bus.i_wr_stock_id = 2'(wr_id);
        tick;
        c++;
        bus.i_wr_valid = 1'b0;
        wait_valid(c, lat);
        chk("stale_lit", bus.o_resp_stale, exp);
        chk("stale_sum", bus.o_sum, 10);
        finish_resp;
    endtask

    initial begin
        int lat;
        logic stale_on;
`ifdef VOLATILITY_READER_STALE_EN
        stale_on = 1'b1;
`else
        stale_on = 1'b0;
`endif
        bus.i_req_valid = 1'b0;
        bus.i_req_stock_id = '0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_stock_id = '0;
        bus.i_resp_ready = 1'b0;
        for (int i = 0; i < BS; i++) begin
            mem[0*BS + i] = 32'hFFFF_FFFF;
            mem[1*BS + i] = 32'(10 * (i + 1));
            mem[2*BS + i] = 32'(i + 1);
            mem[3*BS + i] = 32'd7;
        end

        // reset state
        repeat (3) tick;
        chk("rst_req_ready", bus.o_req_ready, 1);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_rd_addr", bus.o_rd_addr, 0);
        chk("rst_valid", bus.o_resp_valid, 0);
        chk("rst_err", bus.o_resp_err, 0);
        chk("rst_stale", bus.o_resp_stale, 0);
        chk("rst_sum", bus.o_sum, 0);
        chk("rst_sum_sq", bus.o_sum_sq, 0);
        chk("rst_var", bus.o_var_scaled, 0);
        chk("rst_id", bus.o_resp_stock_id, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick;

        // stock 1: 10,20,30,40
        req(1);
        wait_valid(1, lat);
        chk("s1_latency", lat, 7);
        chk("s1_sum", bus.o_sum, 100);
        chk("s1_sum_sq", bus.o_sum_sq, 3000);
        chk("s1_var", bus.o_var_scaled, 2000);
        chk("s1_id", bus.o_resp_stock_id, 1);
        finish_resp;

        // stock 3: all 7
        req(3);
        wait_valid(1, lat);
        chk("s3_sum", bus.o_sum, 28);
        chk("s3_sum_sq", bus.o_sum_sq, 196);
        chk("s3_var", bus.o_var_scaled, 0);
        finish_resp;

        // stock 0: all ones, no wrap
        req(0);
        wait_valid(1, lat);
        chk("s0_sum", bus.o_sum, 34'h3_FFFF_FFFC);
        chk("s0_sum_sq", bus.o_sum_sq, 66'h3_FFFF_FFF8_0000_0004);
        chk("s0_var", bus.o_var_scaled, 0);
        finish_resp;

        // backpressure on stock 2 (1,2,3,4), with a request while busy
        req(2);
        wait_valid(1, lat);
        bus.i_req_valid = 1'b1;
        bus.i_req_stock_id = 2'd3;
        repeat (5) begin
            tick;
            chk("bp_ready_low", bus.o_req_ready, 0);
            chk("bp_sum_held", bus.o_sum, 10);
            chk("bp_var_held", bus.o_var_scaled, 20);
        end
        bus.i_resp_ready = 1'b1;
        tick;
        bus.i_resp_ready = 1'b0;
        chk("bp_idle_ready", bus.o_req_ready, 1);
        chk("bp_valid_drop", bus.o_resp_valid, 0);
        tick;
        bus.i_req_valid = 1'b0;
        chk("bp_next_accept", bus.o_req_ready, 0);
        chk("bp_next_rd", bus.o_rd_en, 1);
        wait_valid(1, lat);
        chk("bp_next_sum", bus.o_sum, 28);
        finish_resp;

        // reset in cycle 3 of a scan
        req(1);
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        chk("mid_rst_rd_en", bus.o_rd_en, 0);
        chk("mid_rst_valid", bus.o_resp_valid, 0);
        rst_n = 1'b1;
        tick;
        chk("mid_rst_ready", bus.o_req_ready, 1);
        req(1);
        wait_valid(1, lat);
        chk("post_rst_sum", bus.o_sum, 100);
        chk("post_rst_sum_sq", bus.o_sum_sq, 3000);
        chk("post_rst_var", bus.o_var_scaled, 2000);
        finish_resp;

        // write snoop: same stock at cycle 2, other stock, window edges
        stale_scan(2, 2, stale_on);
        stale_scan(1, 2, 1'b0);
        stale_scan(2, BS + 1, stale_on);
        stale_scan(2, BS + 2, 1'b0);

        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/volatility_window_reader.md
# volatility_window_reader

Read-side engine for the per-stock mid-price window memory. On request for a stock ID, it scans that stock's BUFFER_SIZE entries through a one-cycle-latency read port. It accumulates the sum and the sum of squares, then returns both with the scaled variance numerator. It sits between the mid-price window RAM (write side owned by the market-data path) and the spread/reference-price pricing logic, which divides the result down.

## Interface
- DATA_WIDTH, 32, mid-price entry width (unsigned)
- BUFFER_SIZE, 20, entries per stock window
- NUM_STOCKS, 4, stocks sharing the memory; stock s entry k lives at address s*BUFFER_SIZE + k
- i_clk  in  1  clock
- i_reset_n  in  1  reset; synchronous, active-low; clock i_clk
- i_req_valid  in  1  scan request
- i_req_stock_id  in  max(1,$clog2(NUM_STOCKS))  stock to scan
- o_req_ready  out  1  high only in IDLE
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  read address
- i_rd_data  in  DATA_WIDTH  read data, valid the cycle after o_rd_en
- i_wr_valid  in  1  snoop of write side
- i_wr_stock_id  in  same as i_req_stock_id  snoop of write-side stock ID
- o_resp_valid  out  1  result valid, held until accepted
- i_resp_ready  in  1  result accept
- o_resp_stock_id  out  stock-ID width  echoed stock
- o_sum  out  SW = DATA_WIDTH+$clog2(BUFFER_SIZE)  sum of entries
- o_sum_sq  out  QW = 2*DATA_WIDTH+$clog2(BUFFER_SIZE)  sum of squares
- o_var_scaled  out  VW = 2*DATA_WIDTH+2*$clog2(BUFFER_SIZE)  BUFFER_SIZE*o_sum_sq − o_sum²
- o_resp_err  out  1  stock ID ≥ NUM_STOCKS
- o_resp_stale  out  1  window written during scan

## Operation
- FSM states: IDLE, READ, DRAIN, FINAL, RESP.
- IDLE: o_req_ready=1. A request is accepted on i_req_valid&o_req_ready.
  - Accepting a request latches the stock ID and clears the accumulators, the index and the stale flag.
  - In-range ID goes to READ.
  - Out-of-range ID goes directly to RESP with all data outputs 0 and o_resp_err=1. No reads are issued.
- READ: issues o_rd_en with o_rd_addr = base + k, k = 0..BUFFER_SIZE−1, one per cycle, no gaps. After k = BUFFER_SIZE−1, go to DRAIN.
- Accumulate on every cycle following an o_rd_en: sum += i_rd_data, sum_sq += i_rd_data².
  - Arithmetic is unsigned and zero-extended.
  - No overflow is possible at the given widths. Max inputs must not wrap.
- DRAIN: absorbs the final read-data beat, then goes to FINAL.
- FINAL: computes o_var_scaled in VW bits.
  - The result is guaranteed ≥ 0, so no saturation is needed.
  - Registers all response outputs, then goes to RESP.
- RESP: o_resp_valid=1. All response outputs are stable until i_resp_ready. On the handshake, go to IDLE.
- Entries never written read as their reset value (0). Cold-start windows include those zeros. Fill tracking is the caller's responsibility.
- o_rd_en=0 outside READ. o_rd_addr is don't-care when o_rd_en=0.
- Reset at any point: return to IDLE at the next edge and abort any scan in flight, with no response.
- Reset values: o_req_ready=1 after reset release. o_rd_en, o_resp_valid, o_resp_err and o_resp_stale are 0. All data outputs, o_resp_stock_id and o_rd_addr are 0.

## Timing
- Request accepted at edge 0. o_rd_en is high in cycles 1..BUFFER_SIZE.
- Data arrives in cycles 2..BUFFER_SIZE+1. DRAIN is cycle BUFFER_SIZE+1. FINAL is cycle BUFFER_SIZE+2.
- o_resp_valid rises at cycle BUFFER_SIZE+3.
- Error path: o_resp_valid rises at cycle 1.
- The earliest next accept is the cycle after the response handshake. Peak throughput is one scan per BUFFER_SIZE+4 cycles.
- i_req_valid asserted while busy is ignored (not queued).

## Configuration
- VOLATILITY_READER_STALE_EN defined:
  - o_resp_stale is set if i_wr_valid with i_wr_stock_id equal to the latched stock occurs in any cycle from 1 through BUFFER_SIZE+1 inclusive.
  - The flag is sticky until the next accept.
- Not defined: o_resp_stale is tied 0 and the snoop inputs are unused.

## Test plan
All scenarios use BUFFER_SIZE=4 and NUM_STOCKS=4. Memory model returns data one cycle after o_rd_en.
- Stock 1 preloaded 10,20,30,40 -> addresses 4,5,6,7 in order. Response: o_sum=100, o_sum_sq=3000, o_var_scaled=2000, o_resp_stock_id=1, valid at cycle 7.
- Stock 3 all 7 -> o_sum=28, o_sum_sq=196, o_var_scaled=0.
- Stock 0 all 0xFFFFFFFF -> o_sum=4*(2^32−1), o_sum_sq=4*(2^32−1)², o_var_scaled=0, no wrap.
- Backpressure: i_resp_ready low 5 cycles after valid -> outputs held, o_req_ready=0, a second request is ignored. After the handshake, a new request is accepted the next cycle.
- Reset asserted in cycle 3 of a scan -> o_rd_en=0 and o_resp_valid=0 next cycle, o_req_ready=1 after release. A fresh scan then returns correct values.
- With VOLATILITY_READER_STALE_EN:
  - A write to stock 2 at cycle 2 of a stock-2 scan -> o_resp_stale=1.
  - A write to stock 1 instead -> o_resp_stale=0.
